// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci stack engine: FSM states, frame phases and the
// LIFO frame layout. Frames use fixed maximum field widths so one typedef serves every instance.
package fib_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RET  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PH_CALL1 = 2'd0,
        PH_CALL2 = 2'd1,
        PH_SUM   = 2'd2
    } ph_e;

    localparam int unsigned IDX_MAX_W = 8;
    localparam int unsigned ACC_MAX_W = 32;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        ph_e                  ph;
        logic [ACC_MAX_W-1:0] acc;
    } frame_t;

    function automatic frame_t mk_frame(input logic [IDX_MAX_W-1:0] idx,
                                        input ph_e                  ph,
                                        input logic [ACC_MAX_W-1:0] acc);
        frame_t f;
        f.idx = idx;
        f.ph  = ph;
        f.acc = acc;
        return f;
    endfunction

endpackage

// File: rtl/fib_stack.sv
// Frame LIFO for the Fibonacci engine: push, pop and in-place rewrite of the top entry.
// A push and a top rewrite may happen in the same cycle (they address different slots).
module fib_stack #(
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               wr_top,
    input  logic [FRAME_W-1:0] push_data,
    input  logic [FRAME_W-1:0] top_wdata,
    output logic [FRAME_W-1:0] top_data,
    output logic               empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [AW:0]        sp_q, sp_d;
    logic [AW-1:0]      top_ptr;
    logic [AW-1:0]      push_ptr;

    assign top_ptr  = AW'(sp_q - 1'b1);
    assign push_ptr = AW'(sp_q);
    assign top_data = mem_q[top_ptr];
    assign empty    = (sp_q == '0);

    always_comb begin
        sp_d = sp_q;
        if (push && !pop) begin
            sp_d = sp_q + 1'b1;
        end else if (pop && !push) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[push_ptr] <= push_data;
        end
        if (wr_top) begin
            mem_q[top_ptr] <= top_wdata;
        end
    end

endmodule

// File: rtl/fib_stack_engine.sv
// Fibonacci engine (fib(0)=fib(1)=1) evaluated by explicit recursion over a frame LIFO.
// Optional macro FIB_OVF_EN: saturate on adder carry and report a sticky ovf flag.
module fib_stack_engine
    import fib_pkg::*;
#(
    parameter int N_W   = 3,
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic [OUT_W-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned DEPTH   = 1 << N_W;
    localparam int unsigned FRAME_W = $bits(frame_t);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] retval_q, retval_d;
    logic [OUT_W-1:0] out_q, out_d;

    logic   push, pop, wr_top, empty;
    frame_t push_frame, wr_frame, top_frame;
    logic   top_leaf;

`ifdef FIB_OVF_EN
    logic             ovf_q, ovf_d;
    logic [OUT_W:0]   sum_w;
`else
    logic [OUT_W-1:0] sum_w;
`endif

    fib_stack #(
        .FRAME_W (FRAME_W),
        .DEPTH   (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_top    (wr_top),
        .push_data (push_frame),
        .top_wdata (wr_frame),
        .top_data  (top_frame),
        .empty     (empty)
    );

    assign top_leaf = (top_frame.idx < IDX_MAX_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_EVAL;
            S_EVAL:         if (top_leaf) state_d = S_RET;
            S_RET: begin
                if (empty) begin
                    state_d = S_DONE;
                end else if (top_frame.ph == PH_CALL2) begin
                    state_d = S_EVAL;
                end
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        wr_top     = 1'b0;
        push_frame = '0;
        wr_frame   = top_frame;
        retval_d   = retval_q;
        out_d      = out_q;
`ifdef FIB_OVF_EN
        ovf_d      = ovf_q;
        sum_w      = {1'b0, top_frame.acc[OUT_W-1:0]} + {1'b0, retval_q};
`else
        sum_w      = top_frame.acc[OUT_W-1:0] + retval_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    push       = 1'b1;
                    push_frame = mk_frame(IDX_MAX_W'(n), PH_CALL1, '0);
`ifdef FIB_OVF_EN
                    ovf_d      = 1'b0;
`endif
                end
            end
            S_EVAL: begin
                if (top_leaf) begin
                    pop      = 1'b1;
                    retval_d = OUT_W'(1);
                end else begin
                    wr_top     = 1'b1;
                    wr_frame   = mk_frame(top_frame.idx, PH_CALL2, top_frame.acc);
                    push       = 1'b1;
                    push_frame = mk_frame(top_frame.idx - IDX_MAX_W'(1), PH_CALL1, '0);
                end
            end
            S_RET: begin
                if (empty) begin
                    out_d = retval_q;
                end else if (top_frame.ph == PH_CALL2) begin
                    // First child's result parks in the frame while the second child runs
                    wr_top     = 1'b1;
                    wr_frame   = mk_frame(top_frame.idx, PH_SUM, ACC_MAX_W'(retval_q));
                    push       = 1'b1;
                    push_frame = mk_frame(top_frame.idx - IDX_MAX_W'(2), PH_CALL1, '0);
                end else if (top_frame.ph == PH_SUM) begin
                    pop = 1'b1;
`ifdef FIB_OVF_EN
                    if (sum_w[OUT_W] || ovf_q) begin
                        retval_d = '1;
                        ovf_d    = 1'b1;
                    end else begin
                        retval_d = sum_w[OUT_W-1:0];
                    end
`else
                    retval_d = sum_w;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retval_q <= '0;
            out_q    <= '0;
        end else begin
            retval_q <= retval_d;
            out_q    <= out_d;
        end
    end

`ifdef FIB_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out  = out_q;
    assign done = (state_q == S_DONE);
    assign busy = (state_q == S_EVAL) || (state_q == S_RET);

endmodule

// File: doc/fib_stack_engine.md
FIB_STACK_ENGINE -- requirements
Module: fib_stack_engine

Interface
REQ-001 The module SHALL have parameter N_W, default 3, meaning the index input width (max index 2^N_W-1).
REQ-002 The module SHALL have parameter OUT_W, default 5, meaning the result width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port start  input  1  computation request, sampled in IDLE or DONE.
REQ-006 The module SHALL have port n  input  N_W  Fibonacci index, captured with start.
REQ-007 The module SHALL have port out  output  OUT_W  result, valid while done=1.
REQ-008 The module SHALL have port done  output  1  result valid; high in DONE only.
REQ-009 The module SHALL have port busy  output  1  high in EVAL or RET.
REQ-010 The module SHALL have port ovf  output  1  sticky overflow flag for the current result.

Function
REQ-011 The module SHALL compute fib(0)=1, fib(1)=1, fib(k)=fib(k-1)+fib(k-2) by explicit recursion on an internal LIFO of frames {idx N_W, ph 2b, acc OUT_W}.
REQ-012 The LIFO depth SHALL be 2^N_W frames; it SHALL never overflow for any legal n.
REQ-013 The FSM SHALL have states IDLE, EVAL, RET, DONE, with one transition per clock.
REQ-014 In IDLE or DONE, with start=1, the module SHALL push {n,0,0}, clear ovf, and go to EVAL; with start=0 it SHALL hold state.
REQ-015 In EVAL, if top.idx<=1, the module SHALL pop, set retval=1, and go to RET.
REQ-016 In EVAL, if top.idx>1, the module SHALL set top.ph=1, push {idx-1,0,0}, and stay in EVAL.
REQ-017 In RET with an empty stack, the module SHALL load out=retval and go to DONE.
REQ-018 In RET with top.ph=1, the module SHALL set top.acc=retval and top.ph=2, push {idx-2,0,0}, and go to EVAL.
REQ-019 In RET with top.ph=2, the module SHALL set retval=top.acc+retval (OUT_W bits), pop, and stay in RET.
REQ-020 For n=0, done SHALL go high at the third rising edge, counting the start-sampling edge as the first.
REQ-021 done and out SHALL hold stable in DONE until the next start.
REQ-022 start asserted during EVAL or RET SHALL be ignored; n SHALL NOT be re-sampled.
REQ-023 The module SHALL accept back-to-back requests: start in DONE begins a new computation and deasserts done on the next edge.

Reset
REQ-024 While rst=0, the module SHALL force state=IDLE, stack pointer=0, out=0, done=0, busy=0, ovf=0, independent of clk.
REQ-025 Reset asserted mid-computation SHALL abort it; after release, no done pulse SHALL occur without a new start.

Configuration
REQ-026 With macro FIB_OVF_EN defined, a carry out of any REQ-019 addition SHALL set ovf, and the retval SHALL saturate to all-ones for the remainder of that computation.
REQ-027 Without FIB_OVF_EN, additions SHALL wrap modulo 2^OUT_W, and ovf SHALL be tied to 0 (the port remains present).

Structure
REQ-028 Package fib_pkg SHALL hold the FSM state enum, the phase encoding (PH_CALL1=0, PH_CALL2=1, PH_SUM=2), and the frame struct typedef.
REQ-029 The LIFO SHALL be sub-module fib_stack (push/pop/top/empty, parameterised on frame width and depth), instanced once.

Verification
REQ-030 Bench SHALL check defaults with n=0..7 sequentially -> out=1,1,2,3,5,8,13,21, done high, ovf=0 each time.
REQ-031 Bench SHALL check N_W=4, OUT_W=5, n=8 -> without FIB_OVF_EN out=2 and ovf=0; with FIB_OVF_EN out=31 and ovf=1.
REQ-032 Bench SHALL check n=0 latency -> done rises exactly at the third edge per REQ-020; busy is high for the two intervening cycles.
REQ-033 Bench SHALL check start pulsed with n=2 while computing n=6 -> out=13, and exactly one done rise.
REQ-034 Bench SHALL check rst=0 mid-computation of n=7 -> all outputs 0 immediately; then start with n=4 -> out=5.
REQ-035 Bench SHALL check start held high in DONE with n=3 following n=5 -> out=8, then done low next cycle, then out=3.
